// File: rtl/frame_tx_arbiter.sv
// Round-robin arbiter that serialises one 16-bit command word per grant as a 4-byte radio frame.
// Optional FRAME_TX_ARB_KILL_PRIO_EN: requester 0 (kill path) wins strictly over round-robin.
module frame_tx_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int GRANT_W = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             veh_id,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*16-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             tx_frame,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [GRANT_W-1:0]     grant_id,
    output logic                   busy
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t               state_reg;
    logic [1:0]           byte_idx_reg;
    logic [GRANT_W-1:0]   last_grant_reg;
    logic [GRANT_W-1:0]   grant_id_reg;
    logic [15:0]          data_reg;
    logic [7:0]           veh_reg;
    logic [7:0]           tx_frame_reg;
    logic                 tx_valid_reg;
    logic                 busy_reg;

    logic [15:0]          req_word [NUM_REQ];
    logic [GRANT_W-1:0]   cand;
    logic [GRANT_W-1:0]   rr_winner;
    logic                 rr_any;
    logic [GRANT_W-1:0]   winner;
    logic                 win_any;
    logic                 upd_ptr;
    logic [7:0]           checksum;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_word[gi]  = req_data[16*gi +: 16];
            assign req_ready[gi] = (state_reg == IDLE) && win_any && (winner == GRANT_W'(gi));
        end
    endgenerate

    // Scan starts one past the last owner so the previous winner ends up lowest priority.
    always_comb begin
        cand      = '0;
        rr_winner = '0;
        rr_any    = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GRANT_W'((int'(last_grant_reg) + k) % NUM_REQ);
            if (!rr_any && req_valid[cand]) begin
                rr_any    = 1'b1;
                rr_winner = cand;
            end
        end
    end

`ifdef FRAME_TX_ARB_KILL_PRIO_EN
    // Kill path preempts and leaves the pointer for requesters 1.. untouched.
    assign winner  = req_valid[0] ? '0 : rr_winner;
    assign win_any = rr_any;
    assign upd_ptr = !req_valid[0];
`else
    assign winner  = rr_winner;
    assign win_any = rr_any;
    assign upd_ptr = 1'b1;
`endif

    assign checksum = veh_reg ^ data_reg[15:8] ^ data_reg[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            byte_idx_reg   <= 2'd0;
            last_grant_reg <= GRANT_W'(NUM_REQ - 1);
            grant_id_reg   <= '0;
            data_reg       <= 16'h0000;
            veh_reg        <= 8'h00;
            tx_frame_reg   <= 8'h00;
            tx_valid_reg   <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (win_any) begin
                        data_reg     <= req_word[winner];
                        veh_reg      <= veh_id;
                        grant_id_reg <= winner;
                        if (upd_ptr) begin
                            last_grant_reg <= winner;
                        end
                        byte_idx_reg <= 2'd0;
                        tx_frame_reg <= veh_id;
                        tx_valid_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                        state_reg    <= SEND;
                    end
                end
                SEND: begin
                    // Next byte is preloaded on each handshake so tx_frame stays put during stalls.
                    if (tx_ready) begin
                        byte_idx_reg <= byte_idx_reg + 2'd1;
                        case (byte_idx_reg)
                            2'd0: tx_frame_reg <= data_reg[15:8];
                            2'd1: tx_frame_reg <= data_reg[7:0];
                            2'd2: tx_frame_reg <= checksum;
                            default: begin
                                tx_frame_reg <= 8'h00;
                                tx_valid_reg <= 1'b0;
                                busy_reg     <= 1'b0;
                                byte_idx_reg <= 2'd0;
                                state_reg    <= IDLE;
                            end
                        endcase
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign tx_frame = tx_frame_reg;
    assign tx_valid = tx_valid_reg;
    assign grant_id = grant_id_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_frame_tx_arbiter.sv
// Scoreboard bench for frame_tx_arbiter: stimulus queues expected grants/bytes, a monitor checks them.
module tb_frame_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int GRANT_W = $clog2(NUM_REQ);

    logic                  clk = 1'b0;
    logic                  rst;
    logic [7:0]            veh_id;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*16-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic [7:0]            tx_frame;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [GRANT_W-1:0]    grant_id;
    logic                  busy;

    frame_tx_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .veh_id    (veh_id),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_frame  (tx_frame),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int acc_count = 0;
    int cyc = 0;
    int prev_acc_cyc = -1;
    bit gap_en = 1'b0;
    logic [7:0] exp_bytes [$];
    int         exp_grants [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input int g, input logic [7:0] v, input logic [15:0] d, input logic [7:0] cs);
        exp_grants.push_back(g);
        exp_bytes.push_back(v);
        exp_bytes.push_back(d[15:8]);
        exp_bytes.push_back(d[7:0]);
        exp_bytes.push_back(cs);
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on each handshake.
    always @(negedge clk) begin
        cyc++;
        if (!gap_en) prev_acc_cyc = -1;
        if (!rst) begin
            if (tx_valid && tx_ready) begin
                if (exp_bytes.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_byte: got %0h required none", tx_frame);
                end else begin
                    logic [7:0] eb;
                    eb = exp_bytes.pop_front();
                    $display("tx byte %02h (expected %02h)", tx_frame, eb);
                    check("tx_byte", {24'h0, tx_frame}, {24'h0, eb});
                end
            end
            if (!tx_valid) check("idle_frame_zero", {24'h0, tx_frame}, 32'h0);
            if (|(req_valid & req_ready)) begin
                int idx;
                idx = 0;
                for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) idx = i;
                acc_count++;
                check("ready_onehot", {28'h0, req_ready}, 32'(1) << idx);
                if (exp_grants.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_grant: got %0d required none", idx);
                end else begin
                    int eg;
                    eg = exp_grants.pop_front();
                    $display("grant to requester %0d (expected %0d)", idx, eg);
                    check("grant_idx", idx, eg);
                end
                if (gap_en && prev_acc_cyc >= 0) check("accept_gap", cyc - prev_acc_cyc, 5);
                if (gap_en) prev_acc_cyc = cyc;
            end
        end
    end

    task automatic send_req(input int i, input logic [15:0] d);
        bit ok;
        ok = 1'b0;
        req_data[16*i +: 16] = d;
        req_valid[i] = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (req_ready[i] && req_valid[i]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: got no acceptance required acceptance of %0d", i);
        end
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_acc(input int target);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (acc_count >= target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL acc_timeout: got %0d acceptances required %0d", acc_count, target);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!busy && !tx_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL idle_timeout: got busy=%0b required 0", busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        int base;
        rst = 1'b1;
        veh_id = 8'h2A;
        req_valid = '0;
        req_data = '0;
        tx_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready", {28'h0, req_ready}, 32'h0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_tx_frame", {24'h0, tx_frame}, 32'h0);
        check("rst_grant_id", 32'(grant_id), 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Single request from requester 1
        push_frame(1, 8'h2A, 16'h1234, 8'h0C);
        send_req(1, 16'h1234);
        check("t1_grant_id", 32'(grant_id), 32'd1);
        busy_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        check("t1_busy_cycles", busy_cnt, 4);
        wait_idle();

        // All-ones word, checksum FF
        veh_id = 8'hFF;
        push_frame(2, 8'hFF, 16'hFFFF, 8'hFF);
        send_req(2, 16'hFFFF);
        wait_idle();
        veh_id = 8'h2A;

        // Stall while byte 1 presented; veh_id change mid-frame is ignored
        push_frame(1, 8'h2A, 16'h1234, 8'h0C);
        send_req(1, 16'h1234);
        @(posedge clk); #1;
        tx_ready = 1'b0;
        veh_id = 8'h55;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_frame", {24'h0, tx_frame}, 32'h12);
            check("stall_valid", {31'h0, tx_valid}, 32'h1);
        end
        @(posedge clk); #1;
        tx_ready = 1'b1;
        veh_id = 8'h2A;
        wait_idle();

        // Reset mid-frame after byte 1 accepted
        exp_grants.push_back(1);
        exp_bytes.push_back(8'h2A);
        exp_bytes.push_back(8'h12);
        send_req(1, 16'h1234);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_tx_frame", {24'h0, tx_frame}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_data[16*1 +: 16] = 16'h1234;
        req_data[16*3 +: 16] = 16'hABCD;
        push_frame(1, 8'h2A, 16'h1234, 8'h0C);
        push_frame(3, 8'h2A, 16'hABCD, 8'h4C);
        base = acc_count;
        req_valid = 4'b1010;
        wait_acc(base + 1);
        req_valid[1] = 1'b0;
        wait_acc(base + 2);
        req_valid[3] = 1'b0;
        wait_idle();

        // All four requesters held after reset
        pulse_reset();
        req_data = {16'h00FF, 16'hA5A5, 16'h1234, 16'h0001};
`ifdef FRAME_TX_ARB_KILL_PRIO_EN
        for (int k = 0; k < 5; k++) push_frame(0, 8'h2A, 16'h0001, 8'h2B);
`else
        push_frame(0, 8'h2A, 16'h0001, 8'h2B);
        push_frame(1, 8'h2A, 16'h1234, 8'h0C);
        push_frame(2, 8'h2A, 16'hA5A5, 8'h2A);
        push_frame(3, 8'h2A, 16'h00FF, 8'hD5);
        push_frame(0, 8'h2A, 16'h0001, 8'h2B);
`endif
        gap_en = 1'b1;
        base = acc_count;
        req_valid = 4'b1111;
        wait_acc(base + 5);
        req_valid = '0;
        wait_idle();
        gap_en = 1'b0;

        // Requesters 0 and 2 held
        pulse_reset();
`ifdef FRAME_TX_ARB_KILL_PRIO_EN
        for (int k = 0; k < 4; k++) push_frame(0, 8'h2A, 16'h0001, 8'h2B);
`else
        push_frame(0, 8'h2A, 16'h0001, 8'h2B);
        push_frame(2, 8'h2A, 16'hA5A5, 8'h2A);
        push_frame(0, 8'h2A, 16'h0001, 8'h2B);
        push_frame(2, 8'h2A, 16'hA5A5, 8'h2A);
`endif
        gap_en = 1'b1;
        base = acc_count;
        req_valid = 4'b0101;
        wait_acc(base + 4);
        req_valid = '0;
        wait_idle();
        gap_en = 1'b0;

        repeat (3) @(negedge clk);
        check("bytes_drained", exp_bytes.size(), 0);
        check("grants_drained", exp_grants.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
